// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit.
// Contents: FSM state enum, opcode constants, alu_op / alu_control codes,
// datapath mux select codes and an immediate-format decode helper.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Internal code from the FSM to the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, never on the state.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's alu_op plus instruction fields to an ALU
// operation code.
// Ports: alu_op (from FSM), funct3, op_b5 (instr[5]), funct7b5 (instr[30]),
//        alu_control (3-bit code, zero-extended to ALU_CTRL_W).
module alu_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            alu_op,
  input  logic [2:0]            funct3,
  input  logic                  op_b5,
  input  logic                  funct7b5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [2:0] ctrl;

  always_comb begin
    ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) can subtract; addi ignores instr[30].
          3'b000:  ctrl = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ctrl = ALU_SLT;
          3'b110:  ctrl = ALU_OR;
          3'b111:  ctrl = ALU_AND;
          default: ctrl = ALU_ADD;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(ctrl);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: Moore FSM sequencing fetch / decode /
// execute / memory / writeback, with built-in ALU and immediate decoders.
// Inputs:  clk, reset (sync, active-high), op, funct3, funct7b5, zero,
//          mem_ready (memory access completes this cycle).
// Outputs: pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
//          alu_src_b, alu_control, imm_src, reg_write, illegal_instr,
//          state_o (debug view of the current state).
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int ALU_CTRL_W    = 3,
  parameter int STATE_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  funct7b5,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [1:0]            imm_src,
  output logic                  reg_write,
  output logic                  illegal_instr,
  output logic [STATE_W-1:0]    state_o
);

  state_t     state_reg, state_next;
  logic       mem_rdy;
  logic       pc_update, branch;
  logic       ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;
  logic [1:0] alu_op;

  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    state_next = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_next = mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: state_next = mem_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_next = S_ALUWB;
      S_ALUWB,
      S_BEQ:      state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // Output logic (Moore, except the memory-ready qualification in FETCH).
  always_comb begin
    adr_src       = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALURESULT;
        ir_write_raw = mem_rdy;
        pc_update    = mem_rdy;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: illegal_raw = 1'b0;
          default:                                  illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = RES_DATA;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gates every architectural write combinationally, so asserting it
  // mid-instruction suppresses the write in that same cycle.
  assign pc_write      = (pc_update | (branch & zero)) & ~reset;
  assign ir_write      = ir_write_raw  & ~reset;
  assign mem_write     = mem_write_raw & ~reset;
  assign reg_write     = reg_write_raw & ~reset;
  assign illegal_instr = illegal_raw   & ~reset;

  assign imm_src = imm_sel(op);
  assign state_o = STATE_W'(state_reg);

  alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .op_b5      (op[5]),
    .funct7b5   (funct7b5),
    .alu_control(alu_control)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Inputs change just after the
// falling edge; outputs are sampled 1 ns later, well before the next rising
// edge, and compared as one packed control word per cycle.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .adr_src      (adr_src),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .result_src   (result_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_control  (alu_control),
    .imm_src      (imm_src),
    .reg_write    (reg_write),
    .illegal_instr(illegal_instr),
    .state_o      (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Word layout: st pcw adr mw irw res sa sb aluc imm rw ill
  function automatic logic [31:0] pk(input logic [3:0] st, input logic pcw, input logic adr,
                                     input logic mw, input logic irw, input logic [1:0] res,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] aluc, input logic [1:0] imm,
                                     input logic rw, input logic ill);
    return {11'b0, st, pcw, adr, mw, irw, res, sa, sb, aluc, imm, rw, ill};
  endfunction

  // Check this cycle's outputs, then advance to the next falling edge.
  task automatic cc(input string tag, input logic [3:0] st, input logic pcw, input logic adr,
                    input logic mw, input logic irw, input logic [1:0] res,
                    input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] aluc,
                    input logic [1:0] imm, input logic rw, input logic ill);
    #1;
    check(tag,
          pk(state_o, pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
             alu_src_b, alu_control, imm_src, reg_write, illegal_instr),
          pk(st, pcw, adr, mw, irw, res, sa, sb, aluc, imm, rw, ill));
    @(negedge clk);
  endtask

  task automatic fetch_ok(input string tag, input logic [1:0] imm);
    mem_ready = 1'b1;
    cc({tag, ".fetch"}, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0);
  endtask

  task automatic decode_ok(input string tag, input logic [1:0] imm);
    cc({tag, ".decode"}, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, 1'b0);
  endtask

  // R-type (state 6, B=rs2) or I-type ALU (state 7, B=imm) instruction.
  task automatic run_alu(input string tag, input logic [6:0] opv, input logic [2:0] f3,
                         input logic f7, input logic [2:0] exp_aluc);
    logic [3:0] st_exec;
    logic [1:0] sb;
    op = opv; funct3 = f3; funct7b5 = f7; zero = 1'b0;
    st_exec = (opv == 7'b0110011) ? 4'd6 : 4'd7;
    sb      = (opv == 7'b0110011) ? 2'b00 : 2'b01;
    fetch_ok(tag, 2'b00);
    decode_ok(tag, 2'b00);
    cc({tag, ".exec"}, st_exec, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, sb, exp_aluc, 2'b00, 1'b0, 1'b0);
    cc({tag, ".aluwb"}, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0);
    $display("txn %s op=%b funct3=%b f7b5=%b done", tag, opv, f3, f7);
  endtask

  task automatic run_beq(input string tag, input logic z);
    op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; zero = z;
    fetch_ok(tag, 2'b10);
    decode_ok(tag, 2'b10);
    cc({tag, ".beq"}, 4'd9, z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0, 1'b0);
    $display("txn %s zero=%b done", tag, z);
  endtask

  initial begin
    reset = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);

    // Reset held two cycles: FETCH, but all enables suppressed.
    for (int i = 0; i < 2; i++)
      cc("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    $display("txn reset done");

    // add x3,x1,x2 (0x002081B3), then sub, and, ori, slti, addi with instr[30]=1
    run_alu("add",  7'b0110011, 3'b000, 1'b0, 3'b000);
    run_alu("sub",  7'b0110011, 3'b000, 1'b1, 3'b001);
    run_alu("and",  7'b0110011, 3'b111, 1'b0, 3'b010);
    run_alu("ori",  7'b0010011, 3'b110, 1'b0, 3'b011);
    run_alu("slti", 7'b0010011, 3'b010, 1'b0, 3'b101);
    run_alu("addi", 7'b0010011, 3'b000, 1'b1, 3'b000);

    // lw with three not-ready cycles in MEMREAD
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
    fetch_ok("lw", 2'b00);
    decode_ok("lw", 2'b00);
    cc("lw.memadr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cc("lw.memread_wait", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    mem_ready = 1'b1;
    cc("lw.memread", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0);
    cc("lw.memwb", 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 1'b0);
    $display("txn lw done");

    // sw with three not-ready cycles in MEMWRITE: mem_write high 4 cycles
    op = 7'b0100011;
    fetch_ok("sw", 2'b01);
    decode_ok("sw", 2'b01);
    cc("sw.memadr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cc("sw.memwrite_wait", 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0);
    mem_ready = 1'b1;
    cc("sw.memwrite", 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0);
    $display("txn sw done");

    run_beq("beq_taken", 1'b1);
    run_beq("beq_not_taken", 1'b0);

    // jal
    op = 7'b1101111; zero = 1'b0;
    fetch_ok("jal", 2'b11);
    decode_ok("jal", 2'b11);
    cc("jal.jal", 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 1'b0, 1'b0);
    cc("jal.aluwb", 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1'b1, 1'b0);
    $display("txn jal done");

    // Illegal opcode, preceded by a stalled fetch.
    op = 7'b0000000;
    mem_ready = 1'b0;
    cc("ill.fetch_wait", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0, 1'b0);
    fetch_ok("ill", 2'b00);
    cc("ill.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0, 1'b1);
    $display("txn illegal done");

    // Reset asserted while sw waits in MEMWRITE.
    op = 7'b0100011;
    fetch_ok("swrst", 2'b01);
    decode_ok("swrst", 2'b01);
    cc("swrst.memadr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0, 1'b0);
    mem_ready = 1'b0;
    cc("swrst.memwrite", 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0);
    reset = 1'b1;
    cc("swrst.gated", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 1'b0);
    mem_ready = 1'b1;
    cc("swrst.in_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 1'b0, 1'b0);
    reset = 1'b0;
    fetch_ok("after_reset", 2'b01);
    $display("txn reset_in_memwrite done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
